// File: rtl/seq_divider.sv
// Sequential signed 16/8 divider: restoring radix-2 on magnitudes, truncating (remainder follows dividend sign).
// Latency: done strobes 19 edges after the accepting edge (2 for divide-by-zero); start is ignored while busy.
module seq_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] inDividend,
    input  logic [7:0]  inDivisor,
    output logic [15:0] outQ,
    output logic [7:0]  outRem,
    output logic        busy,
    output logic        done,
    output logic        divByZero,
    output logic        overflow
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state;
    state_t      stateNext;

    logic [15:0] dividendReg;
    logic [7:0]  divisorReg;
    logic [15:0] quoA;
    logic [8:0]  partP;
    logic [7:0]  magDReg;
    logic [3:0]  cnt;
    logic        signQ;
    logic        signR;

    logic [15:0] magA;
    logic [7:0]  magD;
    logic [9:0]  shiftedP;
    logic [9:0]  trial;
    logic        trialNeg;
    logic [15:0] quoNeg;
    logic [7:0]  remNeg;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (start) stateNext = LOAD;
            LOAD: stateNext = (divisorReg == 8'h00) ? DONE : CALC;
            CALC: if (cnt == 4'd15) stateNext = FIX;
            FIX:  stateNext = DONE;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // ------------------------------------------------------------------
    // Datapath combinational helpers
    // ------------------------------------------------------------------
    // 16/8 unsigned result widths are enough: -32768 and -128 negate to 0x8000 / 0x80.
    always_comb begin
        magA     = dividendReg[15] ? (16'd0 - dividendReg) : dividendReg;
        magD     = divisorReg[7]   ? (8'd0 - divisorReg)   : divisorReg;
        shiftedP = {partP, quoA[15]};
        trial    = shiftedP - {2'b00, magDReg};
        trialNeg = trial[9];
        quoNeg   = 16'd0 - quoA;
        remNeg   = 8'd0 - partP[7:0];
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dividendReg <= 16'h0000;
            divisorReg  <= 8'h00;
            quoA        <= 16'h0000;
            partP       <= 9'h000;
            magDReg     <= 8'h00;
            cnt         <= 4'd0;
            signQ       <= 1'b0;
            signR       <= 1'b0;
            outQ        <= 16'h0000;
            outRem      <= 8'h00;
            divByZero   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dividendReg <= inDividend;
                        divisorReg  <= inDivisor;
                        divByZero   <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (divisorReg == 8'h00) begin
                        divByZero <= 1'b1;
                        outQ      <= 16'hFFFF;
                        outRem    <= 8'h00;
                    end else begin
                        quoA    <= magA;
                        magDReg <= magD;
                        signQ   <= dividendReg[15] ^ divisorReg[7];
                        signR   <= dividendReg[15];
                        partP   <= 9'h000;
                        cnt     <= 4'd0;
                    end
                end
                CALC: begin
                    // Quotient bits shift into A from the right as dividend bits leave on the left.
                    partP <= trialNeg ? shiftedP[8:0] : trial[8:0];
                    quoA  <= {quoA[14:0], ~trialNeg};
                    cnt   <= cnt + 4'd1;
                end
                FIX: begin
                    outQ   <= signQ ? quoNeg : quoA;
                    outRem <= signR ? remNeg : partP[7:0];
                    if ((quoA == 16'h8000) && !signQ) begin
                        overflow <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
